// File: rtl/axis_credit_pkg.sv
// Shared definitions for the credit-flow AXI4-Stream link (sink and source ends).
// Both ends size their credit counters and check link legality from these.
package axis_credit_pkg;

  typedef enum logic {
    HEAD_EMPTY = 1'b0,
    HEAD_VALID = 1'b1
  } head_state_e;

  localparam int DEFAULT_DEPTH         = 16;
  localparam int DEFAULT_CREDIT_STAGES = 4;
  localparam int MIN_DEPTH             = 4;
  localparam int MIN_CREDIT_STAGES     = 1;
  // Cycles of round trip beyond the pipeline stages: sink pop decision plus source send decision.
  localparam int RTT_SLACK             = 2;

  // Width that holds any count 0..depth inclusive.
  function automatic int credit_cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit link_cfg_legal(input int depth, input int credit_stages,
                                        input int fwd_stages);
    return (depth >= MIN_DEPTH) &&
           ((depth & (depth - 1)) == 0) &&
           (credit_stages >= MIN_CREDIT_STAGES) &&
           (depth >= fwd_stages + credit_stages + RTT_SLACK);
  endfunction

endpackage

// File: rtl/axis_credit_sink_rtl_if.sv
// AXI4-Stream channel bundle used on the output of the credit sink.
// Handshake: a beat transfers on a clock edge where tvalid and tready are both 1;
// once tvalid is raised, tdata and tvalid hold until that transfer happens.
interface axis_credit_sink_rtl_if #(
  parameter int DATA_BITS = 32
) ();

  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_credit_sink_rtl_credit_delay.sv
// Fixed-latency 1-bit delay line for credit pulses; each input pulse emerges
// STAGES cycles later, so pulses never merge or shift relative to each other.
module credit_delay_rtl #(
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr_q;
  logic [STAGES-1:0] sr_d;

  always_comb begin
    sr_d = (sr_q << 1) | STAGES'(din);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[STAGES-1];

endmodule

// File: rtl/axis_credit_sink_rtl.sv
// Receive end of a credit-flow AXI4-Stream link: buffers valid-only beats,
// re-presents them with full backpressure and returns one credit per freed slot.
module axis_credit_sink_rtl
  import axis_credit_pkg::*;
#(
  parameter int DATA_BITS     = 32,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int CREDIT_STAGES = DEFAULT_CREDIT_STAGES
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [DATA_BITS-1:0]               s_link_tdata,
  input  logic                               s_link_tvalid,
  output logic                               s_link_credit,
  axis_credit_sink_rtl_if.master             m_axis,
  output logic [credit_cnt_bits(DEPTH)-1:0]  occupancy,
  output logic                               overflow,
  output head_state_e                        dbg_head_state
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int OCC_BITS = credit_cnt_bits(DEPTH);
  localparam logic [OCC_BITS-1:0] OCC_FULL = OCC_BITS'(DEPTH);

  head_state_e            head_state_q, head_state_d;
  logic [DATA_BITS-1:0]   head_data_q,  head_data_d;
  logic [PTR_BITS-1:0]    wr_ptr_q,     wr_ptr_d;
  logic [PTR_BITS-1:0]    rd_ptr_q,     rd_ptr_d;
  logic [OCC_BITS-1:0]    store_cnt_q,  store_cnt_d;
  logic [OCC_BITS-1:0]    occ_q,        occ_d;
  logic                   overflow_q,   overflow_d;
  logic                   credit_q,     credit_d;
  logic [DATA_BITS-1:0]   mem_q [DEPTH];

  logic pop;
  logic full;
  logic push;
  logic store_empty;
  logic head_take_push;
  logic store_rd;
  logic mem_we;
  logic credit_line_out;

  // Fullness is judged on the pre-pop count: the transmitter only sends when it
  // holds a credit, so a beat arriving at DEPTH means the link protocol broke.
  always_comb begin
    pop         = (head_state_q == HEAD_VALID) && m_axis.tready;
    full        = (occ_q == OCC_FULL);
    push        = s_link_tvalid && !full;
    store_empty = (store_cnt_q == '0);
    overflow_d  = overflow_q | (s_link_tvalid & full);
  end

  // Head register FSM. A push bypasses storage only when storage is empty,
  // which keeps arrival order and gives one-cycle latency into an empty block.
  always_comb begin
    head_state_d   = head_state_q;
    head_data_d    = head_data_q;
    head_take_push = 1'b0;
    store_rd       = 1'b0;
    case (head_state_q)
      HEAD_EMPTY: begin
        if (!store_empty) begin
          head_data_d  = mem_q[rd_ptr_q];
          store_rd     = 1'b1;
          head_state_d = HEAD_VALID;
        end else if (push) begin
          head_data_d    = s_link_tdata;
          head_take_push = 1'b1;
          head_state_d   = HEAD_VALID;
        end
      end
      HEAD_VALID: begin
        if (pop) begin
          if (!store_empty) begin
            head_data_d = mem_q[rd_ptr_q];
            store_rd    = 1'b1;
          end else if (push) begin
            head_data_d    = s_link_tdata;
            head_take_push = 1'b1;
          end else begin
            head_state_d = HEAD_EMPTY;
          end
        end
      end
      default: begin
        head_state_d = HEAD_EMPTY;
      end
    endcase
  end

  always_comb begin
    mem_we      = push && !head_take_push;
    wr_ptr_d    = mem_we   ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
    rd_ptr_d    = store_rd ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
    store_cnt_d = store_cnt_q + OCC_BITS'(mem_we) - OCC_BITS'(store_rd);
    occ_d       = occ_q + OCC_BITS'(push) - OCC_BITS'(pop);
    credit_d    = credit_line_out;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      head_state_q <= HEAD_EMPTY;
      head_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      store_cnt_q  <= '0;
      occ_q        <= '0;
      overflow_q   <= 1'b0;
      credit_q     <= 1'b0;
    end else begin
      head_state_q <= head_state_d;
      head_data_q  <= head_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      store_cnt_q  <= store_cnt_d;
      occ_q        <= occ_d;
      overflow_q   <= overflow_d;
      credit_q     <= credit_d;
    end
  end

  // Storage array carries no reset; the pointers and counts define validity.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= s_link_tdata;
    end
  end

  // A pop enters the delay line on the same edge; the output flop adds the last
  // stage so the pulse appears CREDIT_STAGES edges after the pop.
  credit_delay_rtl #(
    .STAGES (CREDIT_STAGES)
  ) u_credit_delay (
    .clk  (aclk),
    .clr  (areset),
    .din  (pop),
    .dout (credit_line_out)
  );

  assign m_axis.tdata   = head_data_q;
  assign m_axis.tvalid  = (head_state_q == HEAD_VALID);
  assign s_link_credit  = credit_q;
  assign occupancy      = occ_q;
  assign overflow       = overflow_q;
  assign dbg_head_state = head_state_q;

endmodule

// File: tb/tb_axis_credit_sink_rtl.sv
// Directed and randomized bench for axis_credit_sink_rtl against a queue-based
// model of the buffer, the credit return latency and a credit-holding transmitter.
module tb_axis_credit_sink_rtl;
  import axis_credit_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CS    = 4;

  logic                          aclk;
  logic                          areset;
  logic [DW-1:0]                 s_link_tdata;
  logic                          s_link_tvalid;
  logic                          s_link_credit;
  logic [credit_cnt_bits(DEPTH)-1:0] occupancy;
  logic                          overflow;
  head_state_e                   dbg_state;

  axis_credit_sink_rtl_if #(.DATA_BITS(DW)) m_axis ();

  axis_credit_sink_rtl #(
    .DATA_BITS     (DW),
    .DEPTH         (DEPTH),
    .CREDIT_STAGES (CS)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_link_tdata   (s_link_tdata),
    .s_link_tvalid  (s_link_tvalid),
    .s_link_credit  (s_link_credit),
    .m_axis         (m_axis),
    .occupancy      (occupancy),
    .overflow       (overflow),
    .dbg_head_state (dbg_state)
  );

  // Clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  bit            cred_q[$];
  logic          exp_ovf;
  int            checks;
  int            passes;
  int            fails;
  int            popped;
  int            credits_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    cred_q.delete();
    for (int i = 0; i < CS; i++) cred_q.push_back(1'b0);
    exp_ovf      = 1'b0;
    popped       = 0;
    credits_seen = 0;
  endtask

  // Drivers: called at a negedge, return at the following negedge
  task automatic do_reset();
    areset        = 1'b1;
    s_link_tvalid = 1'b0;
    s_link_tdata  = '0;
    m_axis.tready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    clear_model();
    chk("rst_tvalid",    32'(m_axis.tvalid), 32'd0);
    chk("rst_tdata",     m_axis.tdata,       32'd0);
    chk("rst_occupancy", 32'(occupancy),     32'd0);
    chk("rst_overflow",  32'(overflow),      32'd0);
    chk("rst_credit",    32'(s_link_credit), 32'd0);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    bit pop_now;
    bit full_pre;
    s_link_tvalid = v;
    s_link_tdata  = d;
    m_axis.tready = r;
    if (exp_q.size() > 0) chk("head_data", m_axis.tdata, exp_q[0]);
    full_pre = (exp_q.size() == DEPTH);
    pop_now  = (exp_q.size() > 0) && r;
    if (pop_now) begin
      void'(exp_q.pop_front());
      popped++;
    end
    if (v) begin
      if (full_pre) exp_ovf = 1'b1;
      else          exp_q.push_back(d);
    end
    cred_q.push_back(pop_now);
    @(posedge aclk);
    @(negedge aclk);
    chk("occupancy", 32'(occupancy),     32'(exp_q.size()));
    chk("tvalid",    32'(m_axis.tvalid), 32'(exp_q.size() > 0));
    chk("dbg_state", 32'(dbg_state),     (exp_q.size() > 0) ? 32'(HEAD_VALID) : 32'(HEAD_EMPTY));
    chk("overflow",  32'(overflow),      32'(exp_ovf));
    chk("credit",    32'(s_link_credit), 32'(cred_q.pop_front()));
    if (s_link_credit) credits_seen++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  logic send;
  int   tx_cr;
  int   sent;
  int   phase_pops;

  initial begin
    areset        = 1'b1;
    s_link_tvalid = 1'b0;
    s_link_tdata  = '0;
    m_axis.tready = 1'b0;
    checks = 0; passes = 0; fails = 0;
    clear_model();
    @(negedge aclk);
    do_reset();

    // Back-to-back beats with tready held high
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b1);
    drain(CS + 4);
    chk("b2b_pops",    32'(popped),       32'd16);
    chk("b2b_credits", 32'(credits_seen), 32'd16);

    // Fill with tready low, then one beat too many
    phase_pops = popped;
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0);
    chk("fill_occ", 32'(occupancy), 32'd16);
    step(1'b1, 32'h10, 1'b0);
    drain(DEPTH + CS + 4);
    chk("fill_drained", 32'(popped - phase_pops), 32'd16);
    chk("fill_credits", 32'(credits_seen),        32'(popped));

    // Push and pop in the same cycle with the buffer full
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + DW'(i), 1'b0);
    step(1'b1, 32'h99, 1'b1);
    chk("fullpp_occ", 32'(occupancy), 32'd15);
    chk("fullpp_ovf", 32'(overflow),  32'd1);
    drain(DEPTH + CS + 4);
    chk("fullpp_credits", 32'(credits_seen), 32'(popped));

    // Backpressure hold: tdata must stay put
    do_reset();
    step(1'b1, 32'hA5A5_5A5A, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    chk("hold_tdata", m_axis.tdata, 32'hA5A5_5A5A);
    drain(CS + 3);

    // Randomized traffic under a transmitter holding DEPTH credits
    do_reset();
    tx_cr = DEPTH;
    sent  = 0;
    for (int n = 0; n < 8000; n++) begin
      if (sent >= 1000 && exp_q.size() == 0 && tx_cr == DEPTH) break;
      send = (sent < 1000) && (tx_cr > 0) && ($urandom_range(0, 3) != 0);
      if (send) begin
        tx_cr--;
        sent++;
      end
      step(send, $urandom, 1'($urandom_range(0, 1)));
      if (s_link_credit) tx_cr++;
    end
    chk("rand_sent",       32'(sent),         32'd1000);
    chk("rand_popped",     32'(popped),       32'd1000);
    chk("rand_credits",    32'(credits_seen), 32'(popped));
    chk("rand_tx_credits", 32'(tx_cr),        32'(DEPTH));
    chk("rand_overflow",   32'(overflow),     32'd0);

    // Reset with beats held and credits still in flight
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + DW'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("mid_occ_before", 32'(occupancy), 32'd8);
    do_reset();
    for (int i = 0; i < CS + 4; i++) step(1'b0, '0, 1'b1);
    chk("mid_no_stray_credit", 32'(credits_seen), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
